entropy_src_markov_kat_gen: RTL

//  Drives a known-answer entropy stream into the Markov health test, on the same entropy_bit/vld/window_wrap interface.

---
 rtl/entropy_src_markov_kat_pkg.sv | 23 ++
 rtl/entropy_src_markov_kat_lane.sv | 37 +++
 rtl/entropy_src_markov_kat_gen.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/entropy_src_markov_kat_pkg.sv
// Shared types, LFSR constants and the target clamp helper for the Markov known-answer generator.
// Optional level scrambling is enabled by defining ENTROPY_SRC_MARKOV_KAT_LFSR_EN.
package entropy_src_markov_kat_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StEmit0 = 2'd1,
        StEmit1 = 2'd2,
        StWrap  = 2'd3
    } markov_kat_state_e;

    localparam int unsigned LfsrWidth = 16;
    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting form: feedback from bits 0, 2, 3 and 5
    localparam logic [LfsrWidth-1:0] LfsrTaps = 16'h002D;

    localparam int unsigned ClampWidth = 32;

    function automatic logic [ClampWidth-1:0] clamp_min(input logic [ClampWidth-1:0] a,
                                                        input logic [ClampWidth-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/entropy_src_markov_kat_lane.sv
// One RNG lane: holds its clamped toggling-pair target and forms the lane's sample bit.
module entropy_src_markov_kat_lane
    import entropy_src_markov_kat_pkg::*;
#(
    parameter int unsigned RegWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [RegWidth-1:0] tgt_i,
    input  markov_kat_state_e   state_i,
    input  logic [RegWidth-1:0] pairIdx_i,
    input  logic                base_i,
    output logic                bit_o
);

    logic [RegWidth-1:0] tgt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tgt_q <= '0;
        end else if (load_i) begin
            tgt_q <= tgt_i;
        end
    end

    // Only the second sample of the first tgt pairs in a window flips away from the base level
    always_comb begin
        bit_o = 1'b0;
        case (state_i)
            StEmit0: bit_o = base_i;
            StEmit1: bit_o = (pairIdx_i < tgt_q) ? ~base_i : base_i;
            default: bit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/entropy_src_markov_kat_gen.sv
// Known-answer entropy stream generator for the Markov health test, with expected max/min/sum outputs.
// Defining ENTROPY_SRC_MARKOV_KAT_LFSR_EN scrambles the per-pair base levels with a 16-bit LFSR.
module entropy_src_markov_kat_gen
    import entropy_src_markov_kat_pkg::*;
#(
    parameter int unsigned RegWidth    = 16,
    parameter int unsigned RngBusWidth = 4
`ifdef ENTROPY_SRC_MARKOV_KAT_LFSR_EN
    ,
    parameter logic [LfsrWidth-1:0] LfsrSeed = 16'hACE1
`endif
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic                            abort_i,
    input  logic [RegWidth-1:0]             window_pairs_i,
    input  logic [7:0]                      num_windows_i,
    input  logic [RngBusWidth*RegWidth-1:0] target_pairs_i,
    output logic [RngBusWidth-1:0]          entropy_bit_o,
    output logic                            entropy_bit_vld_o,
    input  logic                            entropy_bit_rdy_i,
    output logic                            window_wrap_pulse_o,
    output logic                            busy_o,
    output logic                            done_pulse_o,
    output logic [RegWidth-1:0]             exp_max_o,
    output logic [RegWidth-1:0]             exp_min_o,
    output logic [RegWidth-1:0]             exp_sum_o
);

    localparam logic [RegWidth-1:0] RegOne = RegWidth'(1);
    localparam logic [7:0]          WinOne = 8'd1;

    markov_kat_state_e   state_q, state_d;
    logic [RegWidth-1:0] pairIdx_q, pairIdx_d;
    logic [7:0]          winIdx_q, winIdx_d;
    logic [RegWidth-1:0] windowPairs_q, windowPairs_d;
    logic [7:0]          numWindows_q, numWindows_d;
    logic                donePulse_q, donePulse_d;
    logic [RegWidth-1:0] expMax_q, expMin_q, expSum_q;
    logic [RegWidth-1:0] redMax, redMin, redSum;
    logic [RegWidth-1:0] tgtClamped [RngBusWidth];
    logic [RngBusWidth-1:0] base;
    logic                loadTgt;

    always_comb begin
        redMax = '0;
        redMin = '1;
        redSum = '0;
        for (int l = 0; l < RngBusWidth; l++) begin
            tgtClamped[l] = RegWidth'(clamp_min(ClampWidth'(target_pairs_i[l*RegWidth +: RegWidth]),
                                                ClampWidth'(window_pairs_i)));
            if (tgtClamped[l] > redMax) redMax = tgtClamped[l];
            if (tgtClamped[l] < redMin) redMin = tgtClamped[l];
            redSum = redSum + tgtClamped[l];
        end
    end

    always_comb begin
        state_d       = state_q;
        pairIdx_d     = pairIdx_q;
        winIdx_d      = winIdx_q;
        windowPairs_d = windowPairs_q;
        numWindows_d  = numWindows_q;
        donePulse_d   = 1'b0;
        loadTgt       = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (window_pairs_i != '0 && num_windows_i != '0) begin
                        state_d       = StEmit0;
                        windowPairs_d = window_pairs_i;
                        numWindows_d  = num_windows_i;
                        pairIdx_d     = '0;
                        winIdx_d      = '0;
                        loadTgt       = 1'b1;
                    end else begin
                        donePulse_d = 1'b1;
                    end
                end
            end
            StEmit0: begin
                if (entropy_bit_rdy_i) state_d = StEmit1;
            end
            StEmit1: begin
                if (entropy_bit_rdy_i) begin
                    if (pairIdx_q == windowPairs_q - RegOne) begin
                        state_d   = StWrap;
                        pairIdx_d = '0;
                    end else begin
                        state_d   = StEmit0;
                        pairIdx_d = pairIdx_q + RegOne;
                    end
                end
            end
            StWrap: begin
                pairIdx_d = '0;
                if (winIdx_q == numWindows_q - WinOne) begin
                    state_d     = StIdle;
                    winIdx_d    = '0;
                    donePulse_d = 1'b1;
                end else begin
                    state_d  = StEmit0;
                    winIdx_d = winIdx_q + WinOne;
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort_i) begin
            state_d     = StIdle;
            pairIdx_d   = '0;
            winIdx_d    = '0;
            donePulse_d = 1'b0;
            loadTgt     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            pairIdx_q     <= '0;
            winIdx_q      <= '0;
            windowPairs_q <= '0;
            numWindows_q  <= '0;
            donePulse_q   <= 1'b0;
            expMax_q      <= '0;
            expMin_q      <= '0;
            expSum_q      <= '0;
        end else begin
            state_q       <= state_d;
            pairIdx_q     <= pairIdx_d;
            winIdx_q      <= winIdx_d;
            windowPairs_q <= windowPairs_d;
            numWindows_q  <= numWindows_d;
            donePulse_q   <= donePulse_d;
            if (loadTgt) begin
                expMax_q <= redMax;
                expMin_q <= redMin;
                expSum_q <= redSum;
            end
        end
    end

`ifdef ENTROPY_SRC_MARKOV_KAT_LFSR_EN
    logic [LfsrWidth-1:0] lfsr_q, lfsr_d;

    // Steps once per completed pair so both samples of a pair share one base level
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == StEmit1 && entropy_bit_rdy_i) begin
            lfsr_d = {^(lfsr_q & LfsrTaps), lfsr_q[LfsrWidth-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign base = lfsr_q[RngBusWidth-1:0];
`else
    assign base = '0;
`endif

    for (genvar l = 0; l < RngBusWidth; l++) begin : gen_lane
        entropy_src_markov_kat_lane #(
            .RegWidth(RegWidth)
        ) u_lane (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .load_i   (loadTgt),
            .tgt_i    (tgtClamped[l]),
            .state_i  (state_q),
            .pairIdx_i(pairIdx_q),
            .base_i   (base[l]),
            .bit_o    (entropy_bit_o[l])
        );
    end

    assign entropy_bit_vld_o   = (state_q == StEmit0) || (state_q == StEmit1);
    assign window_wrap_pulse_o = (state_q == StWrap);
    assign busy_o              = (state_q != StIdle);
    assign done_pulse_o        = donePulse_q;
    assign exp_max_o           = expMax_q;
    assign exp_min_o           = expMin_q;
    assign exp_sum_o           = expSum_q;

endmodule
